// File: rtl/clk_div_pkg.sv
// Shared encodings for the clock divider / CPU clock-enable controller.
package clk_div_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] MODE_FAST = 2'b00;
  localparam logic [STATE_W-1:0] MODE_SLOW = 2'b01;
  localparam logic [STATE_W-1:0] MODE_STEP = 2'b10;
  localparam logic [STATE_W-1:0] MODE_HALT = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    ST_FAST = MODE_FAST,
    ST_SLOW = MODE_SLOW,
    ST_STEP = MODE_STEP,
    ST_HALT = MODE_HALT
  } state_t;

endpackage

// File: rtl/clk_div_ctrl_btn_sync_edge.sv
// Step button conditioner: 2-flop synchroniser, optional debounce
// (CLK_DIV_CTRL_DEBOUNCE_EN) and a registered single-cycle rising-edge pulse.
module btn_sync_edge #(
  parameter int DEB_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic       r_level_d;
  logic       r_pulse;
  logic       w_level;

  if (DEB_W < 1) begin : g_bad_deb_w
    $error("btn_sync_edge: DEB_W must be at least 1");
  end

  // NOTE: every flop here updates with <= so all stages sample the same
  // pre-edge values; blocking assignments would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
    end
  end

`ifdef CLK_DIV_CTRL_DEBOUNCE_EN
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_deb;

  // Any return to the current debounced level restarts the qualification run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_cnt <= '0;
      r_deb     <= 1'b0;
    end else if (r_sync[1] == r_deb) begin
      r_deb_cnt <= '0;
    end else if (&r_deb_cnt) begin
      r_deb_cnt <= '0;
      r_deb     <= r_sync[1];
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_level = r_deb;
`else
  assign w_level = r_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_pulse   <= w_level & ~r_level_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/clk_div_ctrl.sv
// Board clock divider and CPU clock-enable controller (FAST/SLOW/STEP/HALT),
// with a programmable modulo counter. Optional step debounce: CLK_DIV_CTRL_DEBOUNCE_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int FAST_TAP = 2,
  parameter int SLOW_TAP = 24,
  parameter int MOD_W    = 11,
  parameter int DEB_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] mode,
  input  logic               step_btn,
  input  logic [MOD_W-1:0]   mod_val,
  output logic [CNT_W-1:0]   clkdiv,
  output logic               cpu_ce,
  output logic               cpu_clk,
  output logic [MOD_W-1:0]   mod_cnt,
  output logic               mod_wrap,
  output logic [STATE_W-1:0] state
);

  // Counter value one cycle before a tap's enable cycle: 0 followed by TAP ones.
  localparam logic [CNT_W-1:0] FAST_PRE = (CNT_W'(1) << FAST_TAP) - CNT_W'(1);
  localparam logic [CNT_W-1:0] SLOW_PRE = (CNT_W'(1) << SLOW_TAP) - CNT_W'(1);

  if (FAST_TAP >= SLOW_TAP || SLOW_TAP >= CNT_W) begin : g_bad_taps
    $error("clk_div_ctrl: need FAST_TAP < SLOW_TAP < CNT_W");
  end

  logic [CNT_W-1:0] r_clkdiv;
  state_t           r_state;
  logic             r_cpu_ce;
  logic             r_cpu_clk;
  logic [MOD_W-1:0] r_mod_cnt;
  logic             r_mod_wrap;

  state_t w_mode;
  logic   w_step_pulse;
  logic   w_fast_hit;
  logic   w_slow_hit;
  logic   w_ce_next;

  btn_sync_edge #(.DEB_W(DEB_W)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (step_btn),
    .o_pulse (w_step_pulse)
  );

  assign w_mode     = state_t'(mode);
  assign w_fast_hit = (r_clkdiv[FAST_TAP:0] == FAST_PRE[FAST_TAP:0]);
  assign w_slow_hit = (r_clkdiv[SLOW_TAP:0] == SLOW_PRE[SLOW_TAP:0]);

  // NOTE: w_ce_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_ce_next = 1'b0;
    if (w_mode == r_state) begin
      case (r_state)
        ST_FAST: w_ce_next = w_fast_hit;
        ST_SLOW: w_ce_next = w_slow_hit;
        ST_STEP: w_ce_next = w_step_pulse;
        default: w_ce_next = 1'b0;
      endcase
    end
  end

  // A mode change blanks the enable for the cycle the new state takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FAST;
      r_cpu_ce  <= 1'b0;
      r_cpu_clk <= 1'b0;
    end else begin
      r_state   <= w_mode;
      r_cpu_ce  <= w_ce_next;
      r_cpu_clk <= r_cpu_clk ^ r_cpu_ce;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clkdiv   <= '0;
      r_mod_cnt  <= '0;
      r_mod_wrap <= 1'b0;
    end else begin
      r_clkdiv <= r_clkdiv + 1'b1;
      if (mod_val == '0) begin
        r_mod_cnt  <= '0;
        r_mod_wrap <= 1'b0;
      end else if (r_mod_cnt >= mod_val - 1'b1) begin
        r_mod_cnt  <= '0;
        r_mod_wrap <= 1'b1;
      end else begin
        r_mod_cnt  <= r_mod_cnt + 1'b1;
        r_mod_wrap <= 1'b0;
      end
    end
  end

  assign clkdiv   = r_clkdiv;
  assign cpu_ce   = r_cpu_ce;
  assign cpu_clk  = r_cpu_clk;
  assign mod_cnt  = r_mod_cnt;
  assign mod_wrap = r_mod_wrap;
  assign state    = r_state;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl (FAST_TAP=2, SLOW_TAP=4, MOD_W=4, DEB_W=3).
module tb_clk_div_ctrl;
  import clk_div_pkg::*;

  localparam int CNT_W    = 32;
  localparam int FAST_TAP = 2;
  localparam int SLOW_TAP = 4;
  localparam int MOD_W    = 4;
  localparam int DEB_W    = 3;
`ifdef CLK_DIV_CTRL_DEBOUNCE_EN
  localparam int STEP_LAT = (1 << DEB_W) + 3;
`else
  localparam int STEP_LAT = 3;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [STATE_W-1:0] mode;
  logic               step_btn;
  logic [MOD_W-1:0]   mod_val;
  logic [CNT_W-1:0]   clkdiv;
  logic               cpu_ce;
  logic               cpu_clk;
  logic [MOD_W-1:0]   mod_cnt;
  logic               mod_wrap;
  logic [STATE_W-1:0] state;

  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_div;
  logic exp_clk;
  logic last_ce;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W(CNT_W), .FAST_TAP(FAST_TAP), .SLOW_TAP(SLOW_TAP),
    .MOD_W(MOD_W), .DEB_W(DEB_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .step_btn (step_btn),
    .mod_val  (mod_val),
    .clkdiv   (clkdiv),
    .cpu_ce   (cpu_ce),
    .cpu_clk  (cpu_clk),
    .mod_cnt  (mod_cnt),
    .mod_wrap (mod_wrap),
    .state    (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then observed at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle with the expected enable; cpu_clk flips the cycle after an enable.
  task automatic cyc(input logic exp_ce);
    tick();
    exp_clk = exp_clk ^ last_ce;
    exp_div++;
    check($sformatf("clkdiv@%0d", exp_div), clkdiv, exp_div);
    check($sformatf("cpu_ce@%0d", exp_div), {31'd0, cpu_ce}, {31'd0, exp_ce});
    check($sformatf("cpu_clk@%0d", exp_div), {31'd0, cpu_clk}, {31'd0, exp_clk});
    last_ce = exp_ce;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_clkdiv"}, clkdiv, 0);
    check({tag, "_cpu_ce"}, {31'd0, cpu_ce}, 0);
    check({tag, "_cpu_clk"}, {31'd0, cpu_clk}, 0);
    check({tag, "_mod_cnt"}, {28'd0, mod_cnt}, 0);
    check({tag, "_mod_wrap"}, {31'd0, mod_wrap}, 0);
    check({tag, "_state"}, {30'd0, state}, {30'd0, MODE_FAST});
    exp_div = 0;
    exp_clk = 1'b0;
    last_ce = 1'b0;
  endtask

  task automatic mod_step(input int exp_cnt, input int exp_wrap);
    cyc(1'b0);
    check($sformatf("mod_cnt@%0d", exp_div), {28'd0, mod_cnt}, exp_cnt);
    check($sformatf("mod_wrap@%0d", exp_div), {31'd0, mod_wrap}, exp_wrap);
  endtask

  initial begin
    int mc5 [9];
    int mw5 [9];
    int c0;
    mc5 = '{1, 2, 3, 4, 0, 1, 2, 3, 4};
    mw5 = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

    rst = 1'b1; mode = MODE_FAST; step_btn = 1'b0; mod_val = '0;
    tick();
    tick();
    check_reset("rst0");
    rst = 1'b0;

    // FAST: enable while clkdiv = 4, 12, 20, 28, 36.
    for (int d = 1; d <= 40; d++) cyc((d % 8) == 4);

    rst = 1'b1;
    tick();
    check_reset("rst1");
    rst = 1'b0;

    // FAST until clkdiv=10, then SLOW: nothing at 12, enables at 16 and 48.
    for (int d = 1; d <= 10; d++) cyc((d % 8) == 4);
    mode = MODE_SLOW;
    for (int d = 11; d <= 50; d++) begin
      cyc(d == 16 || d == 48);
      if (d == 11) check("state_slow", {30'd0, state}, {30'd0, MODE_SLOW});
    end

    // STEP: button sampled high by the edge starting cycle 100, held to 120.
    mode = MODE_STEP;
    for (int d = 51; d <= 99; d++) cyc(1'b0);
    check("state_step", {30'd0, state}, {30'd0, MODE_STEP});
    step_btn = 1'b1;
    for (int d = 100; d <= 130; d++) begin
      cyc(d == 100 + STEP_LAT);
      if (d == 120) step_btn = 1'b0;
    end

    // HALT: a button press never produces an enable.
    mode = MODE_HALT;
    for (int d = 131; d <= 170; d++) begin
      cyc(1'b0);
      if (d == 135) step_btn = 1'b1;
      if (d == 160) step_btn = 1'b0;
    end
    check("state_halt", {30'd0, state}, {30'd0, MODE_HALT});
    check("mod_zero_cnt", {28'd0, mod_cnt}, 0);
    check("mod_zero_wrap", {31'd0, mod_wrap}, 0);

    // Modulo counter: 5, then 2 while at 4, then 1, then 0.
    mod_val = 4'd5;
    for (int i = 0; i < 9; i++) mod_step(mc5[i], mw5[i]);
    mod_val = 4'd2;
    mod_step(0, 1);
    mod_step(1, 0);
    mod_step(0, 1);
    mod_val = 4'd1;
    mod_step(0, 1);
    mod_step(0, 1);
    mod_val = 4'd0;
    mod_step(0, 0);
    mod_step(0, 0);

    // Reset while a step edge is still in the synchroniser pipeline.
    mod_val = 4'd7;
    mode = MODE_STEP;
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    step_btn = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    check("mod_pre_rst", {28'd0, mod_cnt}, 5);
    rst = 1'b1;
    step_btn = 1'b0;
    tick();
    check_reset("rst2");
    rst = 1'b0;
    for (int d = 1; d <= 14; d++) cyc(1'b0);
    check("state_step2", {30'd0, state}, {30'd0, MODE_STEP});

`ifdef CLK_DIV_CTRL_DEBOUNCE_EN
    // Bounce 1-0-1 then hold: one enable, 11 cycles after the final rise.
    c0 = exp_div;
    step_btn = 1'b1;
    cyc(1'b0);
    step_btn = 1'b0;
    cyc(1'b0);
    step_btn = 1'b1;
    for (int d = c0 + 3; d <= c0 + 30; d++) cyc(d == c0 + 3 + STEP_LAT);
    step_btn = 1'b0;
`else
    c0 = exp_div;
    check("div_after_rst", clkdiv, c0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
